// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, signed/unsigned, valid/ready on both sides
// One product bit per cycle; operands are reduced to magnitudes and the sign is restored on the last step.
module seq_multiplier #(
  parameter  int Width = 8,
  localparam int CntW  = $clog2(Width + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [Width-1:0]   data_in1_i,
  input  logic [Width-1:0]   data_in2_i,
  input  logic               signed_i,
  output logic [2*Width-1:0] data_out_o,
  output logic               data_out_valid_o,
  input  logic               data_out_ready_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2*Width-1:0] r_mcand;
  logic [Width-1:0]   r_mplier;
  logic [2*Width-1:0] r_acc;
  logic [CntW-1:0]    r_cnt;
  logic               r_neg;
  logic [2*Width-1:0] r_data_out;

  logic [Width-1:0]   w_mag1;
  logic [Width-1:0]   w_mag2;
  logic [2*Width-1:0] w_addend;
  logic [2*Width-1:0] w_acc_sum;
  logic [2*Width-1:0] w_result;
  logic               w_last;

  // -2^(Width-1) negates to itself, which read unsigned is exactly its magnitude.
  assign w_mag1    = (signed_i && data_in1_i[Width-1]) ? -data_in1_i : data_in1_i;
  assign w_mag2    = (signed_i && data_in2_i[Width-1]) ? -data_in2_i : data_in2_i;
  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_sum = r_acc + w_addend;
  assign w_result  = r_neg ? -w_acc_sum : w_acc_sum;
  assign w_last    = (r_cnt == CntW'(Width - 1));
  assign data_out_o = r_data_out;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    in_ready_o       = 1'b0;
    data_out_valid_o = 1'b0;
    busy_o           = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) w_state_next = S_CALC;
      end
      S_CALC: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        data_out_valid_o = 1'b1;
        if (data_out_ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_mcand  <= {{Width{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= signed_i & (data_in1_i[Width-1] ^ data_in2_i[Width-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CntW'(1);
          if (w_last) r_data_out <= w_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed vectors and corner sequences for seq_multiplier
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sg, dvalid, dready, busy;
  logic [7:0]  d1, d2;
  logic [15:0] dout;

  logic        in_valid16, in_ready16, sg16, dvalid16, dready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] dout16;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_multiplier #(.Width(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_in1_i(d1), .data_in2_i(d2), .signed_i(sg),
    .data_out_o(dout), .data_out_valid_o(dvalid), .data_out_ready_i(dready),
    .busy_o(busy)
  );

  seq_multiplier #(.Width(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .data_in1_i(a16), .data_in2_i(b16), .signed_i(sg16),
    .data_out_o(dout16), .data_out_valid_o(dvalid16), .data_out_ready_i(dready16),
    .busy_o(busy16)
  );

  typedef struct {
    string       nm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    in_valid = 1'b1; d1 = a; d2 = b; sg = s;
    @(negedge clk);
    in_valid = 1'b0; d1 = '0; d2 = '0; sg = 1'b0;
  endtask

  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [15:0] exp);
    int lat;
    logic rdy_seen;
    launch8(a, b, s);
    lat = 0;
    rdy_seen = 1'b0;
    while (!dvalid && lat < 40) begin
      rdy_seen |= in_ready;
      @(negedge clk);
      lat++;
    end
    rdy_seen |= in_ready;
    check({nm, "_latency"}, lat, 8);
    check({nm, "_in_ready_low"}, rdy_seen, 0);
    check({nm, "_product"}, dout, exp);
    @(negedge clk);
  endtask

  initial begin
    int t0, t1, n, acc_cnt;
    logic seen;
    logic [31:0] e16;

    vecs[0] = '{"u_2x7",      8'd2,   8'd7,   1'b0, 16'd14};
    vecs[1] = '{"u_211x98",   8'd211, 8'd98,  1'b0, 16'd20678};
    vecs[2] = '{"u_123x77",   8'd123, 8'd77,  1'b0, 16'd9471};
    vecs[3] = '{"s_m5x7",     8'hFB,  8'd7,   1'b1, 16'hFFDD};
    vecs[4] = '{"s_m128xm128",8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[5] = '{"s_m128x127", 8'h80,  8'h7F,  1'b1, 16'hC080};
    vecs[6] = '{"s_0xm1",     8'h00,  8'hFF,  1'b1, 16'h0000};
    vecs[7] = '{"u_255x255",  8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[8] = '{"s_m1xm1",    8'hFF,  8'hFF,  1'b1, 16'h0001};

    rst = 1'b1; in_valid = 1'b0; d1 = '0; d2 = '0; sg = 1'b0; dready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sg16 = 1'b0; dready16 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_valid", dvalid, 0);
    check("reset_busy", busy, 0);
    check("reset_dout", dout, 0);

    foreach (vecs[i]) op8(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);

    // Back-to-back acceptance spacing with in_valid held high and ready tied 1.
    in_valid = 1'b1; d1 = 8'd3; d2 = 8'd5; sg = 1'b0;
    acc_cnt = 0; t0 = 0; t1 = 0; n = 0;
    while (acc_cnt < 2 && n < 60) begin
      if (in_ready) begin
        if (acc_cnt == 0) t0 = cyc; else t1 = cyc;
        acc_cnt++;
      end
      if (acc_cnt < 2) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("throughput_spacing", t1 - t0, 10);
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end

    // Output backpressure: product held, new request ignored.
    dready = 1'b0;
    launch8(8'd12, 8'd13, 1'b0);
    n = 0;
    while (!dvalid && n < 40) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; d1 = 8'd1; d2 = 8'd1;
      @(negedge clk);
      check("bp_valid_held", dvalid, 1);
      check("bp_dout_held", dout, 16'd156);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0; dready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", dvalid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_busy", busy, 0);
    check("bp_dout_kept", dout, 16'd156);

    // Reset during iteration 4 of 9x9.
    launch8(8'd9, 8'd9, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_valid", dvalid, 0);
    check("midrst_dout", dout, 0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen |= dvalid;
      @(negedge clk);
    end
    check("midrst_no_valid", seen, 0);
    op8("post_rst_3x3", 8'd3, 8'd3, 1'b0, 16'd9);

    // Width=16 random operands with gaps and output backpressure.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); sg16 = 1'($urandom);
      if (i == 0) begin a16 = 16'h8000; b16 = 16'h8000; sg16 = 1'b1; end
      if (sg16) e16 = $signed(a16) * $signed(b16);
      else      e16 = {16'd0, a16} * {16'd0, b16};
      in_valid16 = 1'b1;
      n = 0;
      while (!in_ready16 && n < 60) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid16 = 1'b0;
      n = 0;
      while (!dvalid16 && n < 60) begin @(negedge clk); n++; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("w16_random", dout16, e16);
      dready16 = 1'b1;
      @(negedge clk);
      dready16 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
